// File: rtl/debug_ring_link_if.sv
// Flit type and per-link two-channel handshake bundle.
// Master drives flits; slave returns per-channel ready.
package dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

interface debug_ring_link_if;
  import dii_pkg::*;
  dii_flit [1:0] flit;
  logic    [1:0] ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);
endinterface

// File: rtl/debug_ring_link.sv
// debug_ring_link: two independent flit FIFOs between ring segments.
// Define DEBUG_RING_LINK_STATS_EN to add pkt_count / fill_level outputs.
module debug_ring_link
  import dii_pkg::*;
#(
  parameter int BUFFER_SIZE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  debug_ring_link_if.slave  link_in,
  debug_ring_link_if.master link_out
`ifdef DEBUG_RING_LINK_STATS_EN
  ,
  output logic [1:0][31:0]  pkt_count,
  output logic [1:0][6:0]   fill_level
`endif
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  logic [16:0]   mem [2][BUFFER_SIZE];
  logic [AW-1:0] rd  [2];
  logic [AW-1:0] wr  [2];
  logic [CW-1:0] cnt [2];

  logic    [1:0] rdy;
  logic    [1:0] push;
  logic    [1:0] pop;
  dii_flit [1:0] out_f;

  // Ready depends on stored count only, never on downstream ready.
  always_comb begin
    rdy   = '0;
    push  = '0;
    pop   = '0;
    out_f = '0;
    for (int c = 0; c < 2; c++) begin
      rdy[c]   = cnt[c] != FULL;
      out_f[c].valid = cnt[c] != '0;
      {out_f[c].last, out_f[c].data} = mem[c][rd[c]];
      push[c]  = link_in.flit[c].valid && rdy[c];
      pop[c]   = out_f[c].valid && link_out.ready[c];
    end
  end

  assign link_in.ready = rdy;
  assign link_out.flit = out_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        rd[c]  <= '0;
        wr[c]  <= '0;
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr[c] <= wr[c] + AW'(1);
        if (pop[c])  rd[c] <= rd[c] + AW'(1);
        unique case (1'b1)
          push[c] && !pop[c]: cnt[c] <= cnt[c] + CW'(1);
          pop[c] && !push[c]: cnt[c] <= cnt[c] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Storage is left unreset; count gates visibility.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem[c][wr[c]] <= {link_in.flit[c].last, link_in.flit[c].data};
      end
    end
  end

`ifdef DEBUG_RING_LINK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (pop[c] && out_f[c].last) begin
          pkt_count[c] <= pkt_count[c] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    fill_level = '0;
    for (int c = 0; c < 2; c++) begin
      fill_level[c] = 7'(cnt[c]);
    end
  end
`endif

endmodule
